// File: rtl/sum_capture_misr.sv
// Capture window for the adder-tree output: skip pipeline fill, count ones, keep the last 32 samples.
// Define SUM_CAPTURE_MISR_EN to build the 16-bit CCITT MISR signature; otherwise signature is tied to zero.
module sum_capture_misr #(
    parameter int NSAMP = 64,
    parameter int SKIP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sum,
    output logic        busy,
    output logic        done,
    output logic [15:0] ones,
    output logic [31:0] last_bits,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_CAPT} state_t;

    localparam logic [7:0]  SKIP_LAST = 8'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [15:0] SAMP_LAST = 16'(NSAMP - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_skip_cnt;
    logic [15:0] r_samp_cnt;
    logic        r_busy, r_done;
    logic [15:0] r_ones;
    logic [31:0] r_last;
    logic        w_accept, w_skip_end, w_capt_end;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_skip_end = (r_skip_cnt == SKIP_LAST);
    assign w_capt_end = (r_samp_cnt == SAMP_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)      w_next = (SKIP > 0) ? ST_SKIP : ST_CAPT;
            ST_SKIP: if (w_skip_end) w_next = ST_CAPT;
            ST_CAPT: if (w_capt_end) w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    // busy is the flopped decode of the next state so it equals (state != IDLE) without combinational paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_skip_cnt <= '0;
            r_samp_cnt <= '0;
            r_ones     <= '0;
            r_last     <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (r_state == ST_CAPT) && w_capt_end;
            if (w_accept) begin
                r_skip_cnt <= '0;
                r_samp_cnt <= '0;
                r_ones     <= '0;
                r_last     <= '0;
            end
            if (r_state == ST_SKIP)
                r_skip_cnt <= r_skip_cnt + 8'd1;
            if (r_state == ST_CAPT) begin
                r_ones     <= r_ones + {15'd0, sum};
                r_last     <= {r_last[30:0], sum};
                r_samp_cnt <= r_samp_cnt + 16'd1;
            end
        end
    end

`ifdef SUM_CAPTURE_MISR_EN
    logic [15:0] r_sig;
    logic        w_fb;

    assign w_fb = r_sig[15] ^ sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sig <= '0;
        else if (w_accept)
            r_sig <= 16'hFFFF;
        else if (r_state == ST_CAPT)
            r_sig <= {r_sig[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
    end

    assign signature = r_sig;
`else
    assign signature = 16'h0000;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign ones      = r_ones;
    assign last_bits = r_last;

endmodule

// File: tb/tb_sum_capture_misr.sv
// Bench for sum_capture_misr: table vectors, directed corner sequences and random windows vs a sample-list model.
module tb_sum_capture_misr;

    localparam int A_SKIP = 4;
    localparam int A_N    = 8;
    localparam int A_LEN  = A_SKIP + A_N;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_start, a_sum, a_busy, a_done;
    logic [15:0] a_ones, a_sig;
    logic [31:0] a_last;
    logic        b_start, b_sum, b_busy, b_done;
    logic [15:0] b_ones, b_sig;
    logic [31:0] b_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_capture_misr #(.NSAMP(A_N), .SKIP(A_SKIP)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .sum(a_sum),
        .busy(a_busy), .done(a_done), .ones(a_ones), .last_bits(a_last), .signature(a_sig));

    sum_capture_misr #(.NSAMP(1), .SKIP(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .sum(b_sum),
        .busy(b_busy), .done(b_done), .ones(b_ones), .last_bits(b_last), .signature(b_sig));

    typedef struct packed {
        logic [15:0] ones;
        logic [31:0] last;
        logic [15:0] sig;
    } res_t;

    typedef struct {
        logic [A_LEN-1:0] bits;   // bits[k] is sum in cycle k after start
        logic [15:0]      ones;
        logic [31:0]      last;
        logic             chk_sig;
        logic [15:0]      sig;
    } vec_t;

`ifdef SUM_CAPTURE_MISR_EN
    localparam bit MISR_ON = 1'b1;
`else
    localparam bit MISR_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Captured samples are the window bits after the skip region; oldest sample lands in the MSB.
    function automatic res_t model(input logic [A_LEN-1:0] bits);
        res_t        r;
        logic [A_N-1:0] c;
        logic [15:0] s;
        for (int i = 0; i < A_N; i++) c[A_N-1-i] = bits[A_SKIP+i];
        r.ones = 16'($countones(c));
        r.last = {{(32-A_N){1'b0}}, c};
        s = 16'hFFFF;
        for (int i = 0; i < A_N; i++)
            s = {s[14:0], 1'b0} ^ ((s[15] ^ bits[A_SKIP+i]) ? 16'h1021 : 16'h0000);
        r.sig = MISR_ON ? s : 16'h0000;
        return r;
    endfunction

    // Entered in an IDLE cycle; returns in the done cycle.
    task automatic run_a(input logic [A_LEN-1:0] bits, input bit keep_start, input string tag);
        res_t e;
        e = model(bits);
        a_start = 1'b1;
        a_sum   = 1'($urandom);
        tick();
        a_start = keep_start;
        chk({tag, " busy after start"}, {31'd0, a_busy}, 32'd1);
        for (int k = 0; k < A_LEN; k++) begin
            a_sum = bits[k];
            tick();
            if (k < A_LEN - 1)
                chk({tag, " busy/done in window"}, {30'd0, a_busy, a_done}, 32'd2);
        end
        chk({tag, " busy/done at end"}, {30'd0, a_busy, a_done}, 32'd1);
        chk({tag, " ones"}, {16'd0, a_ones}, {16'd0, e.ones});
        chk({tag, " last_bits"}, a_last, e.last);
        chk({tag, " signature"}, {16'd0, a_sig}, {16'd0, e.sig});
    endtask

    vec_t tbl[5];
    res_t held;
    logic [A_LEN-1:0] rb;

    initial begin
        tbl[0] = '{12'hFFF, 16'd8, 32'h0000_00FF, 1'b0, 16'h0000};
        tbl[1] = '{12'h000, 16'd0, 32'h0000_0000, 1'b1, MISR_ON ? 16'hE1F0 : 16'h0000};
        tbl[2] = '{12'h00F, 16'd0, 32'h0000_0000, 1'b1, MISR_ON ? 16'hE1F0 : 16'h0000};
        tbl[3] = '{12'h550, 16'd4, 32'h0000_00AA, 1'b0, 16'h0000};
        tbl[4] = '{12'hF00, 16'd4, 32'h0000_000F, 1'b0, 16'h0000};

        rst_n = 1'b0; a_start = 1'b0; a_sum = 1'b0; b_start = 1'b0; b_sum = 1'b0;
        #12;
        chk("reset a outputs", {a_busy, a_done, a_ones, a_sig}, 32'd0);
        chk("reset a last_bits", a_last, 32'd0);
        chk("reset b outputs", {b_busy, b_done, b_ones, b_sig}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Table vectors, separated by one idle cycle that also checks result hold.
        for (int v = 0; v < 5; v++) begin
            run_a(tbl[v].bits, 1'b0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d const ones", v), {16'd0, a_ones}, {16'd0, tbl[v].ones});
            chk($sformatf("vec%0d const last", v), a_last, tbl[v].last);
            if (tbl[v].chk_sig)
                chk($sformatf("vec%0d const sig", v), {16'd0, a_sig}, {16'd0, tbl[v].sig});
            held = {a_ones, a_last, a_sig};
            a_start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("idle busy/done", {30'd0, a_busy, a_done}, 32'd0);
                chk("results held", {16'd0, a_ones}, {16'd0, held.ones});
            end
            chk("last/sig held", {a_last[15:0], a_sig}, {held.last[15:0], held.sig});
        end

        // start held high throughout: back-to-back windows, one done per window.
        run_a(12'hFFF, 1'b1, "b2b1");
        run_a(12'h0F0, 1'b1, "b2b2");
        run_a(12'h000, 1'b1, "b2b3");
        a_start = 1'b0;
        tick();
        chk("b2b idle after", {30'd0, a_busy, a_done}, 32'd0);

        // Random windows, randomly back-to-back.
        for (int r = 0; r < 8; r++) begin
            rb = A_LEN'($urandom);
            run_a(rb, 1'($urandom), $sformatf("rnd%0d", r));
        end
        a_start = 1'b0;
        tick();

        // Asynchronous reset in the middle of capture.
        a_start = 1'b1;
        a_sum   = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("pre-reset busy", {31'd0, a_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset a outputs", {a_busy, a_done, a_ones, a_sig}, 32'd0);
        chk("async reset a last_bits", a_last, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("no done after abandoned window", {30'd0, a_busy, a_done}, 32'd0);
        end
        run_a(12'h5A5, 1'b0, "post-reset");
        a_start = 1'b0;
        tick();

        // SKIP=0, NSAMP=1: capture at the edge right after start.
        b_start = 1'b1;
        b_sum   = 1'b0;
        tick();
        b_start = 1'b0;
        chk("b busy after start", {30'd0, b_busy, b_done}, 32'd2);
        b_sum = 1'b1;
        tick();
        chk("b busy/done", {30'd0, b_busy, b_done}, 32'd1);
        chk("b ones", {16'd0, b_ones}, 32'd1);
        chk("b last_bits", b_last, 32'h1);
        chk("b signature", {16'd0, b_sig}, MISR_ON ? 32'h0000_FFFE : 32'h0);
        tick();
        chk("b done cleared", {30'd0, b_busy, b_done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sum_capture_misr.md
# sum_capture_misr

Downstream capture and compaction stage for the single-bit registered adder-tree output `sum`. After a `start` pulse it discards the tree's pipeline-fill cycles, captures a fixed window of `sum` samples, and reports three results: a ones count, the last 32 samples, and an optional 16-bit MISR signature. Benches and self-check logic use it to compare deduped and non-deduped builds of the tree by comparing these results.

## Interface
- `NSAMP`, default 64: samples captured per window; legal range 1..65535.
- `SKIP`, default 4: cycles discarded after `start` (adder-tree latency); legal range 0..255.

- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begin a capture window; sampled only in IDLE.
- `sum` input 1: tree output bit to capture.
- `busy` output 1: a window is in progress (SKIP or CAPT).
- `done` output 1: one-cycle pulse when the window completes and results are valid.
- `ones` output 16: count of `sum`==1 samples in the window.
- `last_bits` output 32: shift register of captured samples; newest sample in bit 0.
- `signature` output 16: MISR result.

## Operation
- States:
  - IDLE: `start`=1 clears `ones`, `last_bits` and the sample counter, and seeds `signature`=16'hFFFF. Next state is SKIP if `SKIP`>0, else CAPT.
  - SKIP: counts `SKIP` cycles while ignoring `sum`, then goes to CAPT.
  - CAPT: on each edge, captures `sum`:
    - `ones` += `sum`;
    - `last_bits` <= {`last_bits`[30:0], `sum`};
    - MISR step.
  - On the `NSAMP`-th capture: go to IDLE and assert `done` for 1 cycle.
- MISR step uses CCITT polynomial 16'h1021:
  - fb = `signature`[15] ^ `sum`;
  - `signature` <= {`signature`[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0).
- `ones` never wraps: 16 bits is enough for the maximum legal `NSAMP`.
- `start` while `busy` is ignored; the window is neither restarted nor extended.
- Results hold their values after `done` until the next accepted `start`.
- Reset (asynchronous, any time, including mid-window) forces:
  - state IDLE;
  - `busy`=0, `done`=0;
  - `ones`=0, `last_bits`=0, `signature`=0.
- The window is abandoned on reset; no `done` is issued for it.
- `busy` = (state != IDLE). It is a registered decode, not combinational from `start`.

## Timing
- `start` high at edge E (state IDLE):
  - `busy` rises after E;
  - SKIP occupies edges E+1..E+`SKIP`;
  - samples are captured at edges E+`SKIP`+1 .. E+`SKIP`+`NSAMP`.
- `done`=1 and `busy`=0 during the cycle following edge E+`SKIP`+`NSAMP`. Outputs are final in that same cycle.
- A new `start` is accepted in the cycle `done` is high, i.e. at edge E+`SKIP`+`NSAMP`+1. There are no dead cycles between windows.
- `SKIP`=0: the first capture happens at edge E+1.
- Total window from accepted `start` to `done` is `SKIP`+`NSAMP` cycles.

## Configuration
- `SUM_CAPTURE_MISR_EN`:
  - Defined: MISR register and logic are built; `signature` behaves as above.
  - Undefined: no MISR flops; `signature` is a constant 16'h0000 in every state, including after `start`.
- `ones`, `last_bits`, `busy` and `done` are identical in both builds.

## Test plan
- Reset: assert `rst_n`=0 at arbitrary times, including mid-CAPT. Required: all outputs 0 immediately (asynchronously). After release, `start` runs a full window normally.
- `NSAMP`=8, `SKIP`=4, `sum` held 1, `start` at edge 0. Required:
  - `busy` high for edges 1..12;
  - `done` pulses after edge 12;
  - `ones`=8, `last_bits`=32'h000000FF.
- Same configuration with `sum`=0, MISR enabled. Required: `ones`=0, `last_bits`=0, `signature`=16'hE1F0. With the macro undefined: `signature`=16'h0000.
- `NSAMP`=8, `SKIP`=4, `sum` driven 1 only during SKIP, then 0. Required: `ones`=0, which confirms the fill cycles are discarded.
- `start` re-asserted at every edge throughout a window. Required:
  - exactly one `done` per `SKIP`+`NSAMP` cycles;
  - a back-to-back window starts in the `done` cycle;
  - the second window's `ones` reflects only its own samples.
- `SKIP`=0, `NSAMP`=1, `sum`=1. Required: `done` after edge 1, `ones`=1, `last_bits`=32'h1.
